// File: rtl/e203_exu_fpu_fmis_ctrl.sv
// Sequencer for the FPU miscellaneous-op sub-units (fclass, sign-inject, min/max, move).
// Issues one request at a time on a shared operand bus and holds the result until writeback takes it.
module e203_exu_fpu_fmis_ctrl #(
  parameter int NSUB   = 4,
  parameter int ITAG_W = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_valid,
  output logic                 i_ready,
  input  logic [2:0]           i_sel,
  input  logic [31:0]          i_rs1,
  input  logic [31:0]          i_rs2,
  input  logic [ITAG_W-1:0]    i_itag,
  input  logic                 flush,
  output logic [NSUB-1:0]      sub_i_valid,
  input  logic [NSUB-1:0]      sub_i_ready,
  output logic [31:0]          sub_rs1,
  output logic [31:0]          sub_rs2,
  input  logic [NSUB-1:0]      sub_o_valid,
  output logic [NSUB-1:0]      sub_o_ready,
  input  logic [32*NSUB-1:0]   sub_o_wdat,
  output logic                 o_valid,
  input  logic                 o_ready,
  output logic [31:0]          o_wdat,
  output logic [ITAG_W-1:0]    o_itag,
  output logic                 o_illegal
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t              state_r;
  state_t              state_nxt_s;
  logic [2:0]          sel_r;
  logic [31:0]         rs1_r;
  logic [31:0]         rs2_r;
  logic [31:0]         wdat_r;
  logic [ITAG_W-1:0]   itag_r;
  logic                illegal_r;
  logic                kill_r;

  logic [NSUB-1:0]     sel_oh_s;
  logic [31:0]         res_s;
  logic                iss_hs_s;
  logic                res_vld_s;
  logic                accept_s;
  logic                sel_bad_s;
  logic                capture_s;
  logic                kill_set_s;
  logic                kill_clr_s;

  // One-hot decode of the latched select and mux of the selected unit's result
  always_comb begin
    sel_oh_s = '0;
    res_s    = 32'd0;
    for (int k = 0; k < NSUB; k++) begin
      sel_oh_s[k] = (sel_r == 3'(k));
      res_s       = res_s | ({32{sel_oh_s[k]}} & sub_o_wdat[32*k +: 32]);
    end
  end

  assign iss_hs_s  = |(sub_i_ready & sel_oh_s);
  assign res_vld_s = |(sub_o_valid & sel_oh_s);
  assign accept_s  = i_valid & (state_r == IDLE);
  // Full-width compare so a 3-bit select is never truncated against NSUB
  assign sel_bad_s = ({29'd0, i_sel} >= 32'(NSUB));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; flush always wins over forward progress
  always_comb begin
    state_nxt_s = state_r;
    capture_s   = 1'b0;
    kill_set_s  = 1'b0;
    kill_clr_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (i_valid && !flush) begin
          state_nxt_s = sel_bad_s ? RESP : ISSUE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ISSUE: begin
        if (flush) begin
          if (iss_hs_s && !res_vld_s) begin
            kill_set_s  = 1'b1;
            state_nxt_s = WAIT;
          end else begin
            state_nxt_s = IDLE;
          end
        end else if (iss_hs_s && res_vld_s) begin
          capture_s   = 1'b1;
          state_nxt_s = RESP;
        end else if (iss_hs_s) begin
          state_nxt_s = WAIT;
        end else begin
          state_nxt_s = ISSUE;
        end
      end
      WAIT: begin
        if (res_vld_s) begin
          if (kill_r || flush) begin
            kill_clr_s  = 1'b1;
            state_nxt_s = IDLE;
          end else begin
            capture_s   = 1'b1;
            state_nxt_s = RESP;
          end
        end else if (flush) begin
          kill_set_s  = 1'b1;
          state_nxt_s = WAIT;
        end else begin
          state_nxt_s = WAIT;
        end
      end
      RESP: begin
        if (flush || o_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = RESP;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Output decode from the state register
  always_comb begin
    i_ready     = 1'b0;
    sub_i_valid = '0;
    sub_o_ready = '0;
    o_valid     = 1'b0;
    case (state_r)
      IDLE:    i_ready = 1'b1;
      ISSUE: begin
        sub_i_valid = sel_oh_s;
        sub_o_ready = sel_oh_s;
      end
      WAIT:    sub_o_ready = sel_oh_s;
      RESP:    o_valid = 1'b1;
      default: i_ready = 1'b0;
    endcase
  end

  // Request, result and kill registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_r     <= 3'd0;
      rs1_r     <= 32'd0;
      rs2_r     <= 32'd0;
      itag_r    <= '0;
      wdat_r    <= 32'd0;
      illegal_r <= 1'b0;
      kill_r    <= 1'b0;
    end else begin
      if (accept_s) begin
        sel_r     <= i_sel;
        rs1_r     <= i_rs1;
        rs2_r     <= i_rs2;
        itag_r    <= i_itag;
        illegal_r <= sel_bad_s;
        if (sel_bad_s) begin
          wdat_r <= 32'd0;
        end else begin
          wdat_r <= wdat_r;
        end
      end else if (capture_s) begin
        wdat_r <= res_s;
      end else begin
        wdat_r <= wdat_r;
      end
      if (kill_clr_s) begin
        kill_r <= 1'b0;
      end else if (kill_set_s) begin
        kill_r <= 1'b1;
      end else begin
        kill_r <= kill_r;
      end
    end
  end

  assign sub_rs1   = rs1_r;
  assign sub_rs2   = rs2_r;
  assign o_wdat    = wdat_r;
  assign o_itag    = itag_r;
  assign o_illegal = illegal_r;

endmodule

// File: tb/tb_e203_exu_fpu_fmis_ctrl.sv
// Table-driven cycle trace for e203_exu_fpu_fmis_ctrl plus hand-written asynchronous reset sequences.
module tb_e203_exu_fpu_fmis_ctrl;
  localparam int NSUB = 4;
  localparam int ITAG_W = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic i_valid, i_ready, flush, o_valid, o_ready, o_illegal;
  logic [2:0] i_sel;
  logic [31:0] i_rs1, i_rs2, sub_rs1, sub_rs2, o_wdat;
  logic [ITAG_W-1:0] i_itag, o_itag;
  logic [NSUB-1:0] sub_i_valid, sub_i_ready, sub_o_valid, sub_o_ready;
  logic [32*NSUB-1:0] sub_o_wdat;

  int nchecks = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  e203_exu_fpu_fmis_ctrl #(.NSUB(NSUB), .ITAG_W(ITAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_ready(i_ready), .i_sel(i_sel),
    .i_rs1(i_rs1), .i_rs2(i_rs2), .i_itag(i_itag), .flush(flush),
    .sub_i_valid(sub_i_valid), .sub_i_ready(sub_i_ready), .sub_rs1(sub_rs1), .sub_rs2(sub_rs2),
    .sub_o_valid(sub_o_valid), .sub_o_ready(sub_o_ready), .sub_o_wdat(sub_o_wdat),
    .o_valid(o_valid), .o_ready(o_ready), .o_wdat(o_wdat), .o_itag(o_itag), .o_illegal(o_illegal)
  );

  typedef struct {
    logic iv; logic [2:0] sel; logic [31:0] rs1; logic [1:0] itag; logic fl;
    int unit; logic sir; logic sov; logic [31:0] res; logic ordy;
    logic e_irdy; logic [3:0] e_siv; logic [3:0] e_sor; logic e_ov;
    logic [31:0] e_wdat; logic [1:0] e_itag; logic e_ill; logic [31:0] e_rs1;
  } vec_t;

  vec_t vq[$];

  function automatic void add(logic iv, logic [2:0] sel, logic [31:0] rs1, logic [1:0] itag, logic fl,
                              int unit, logic sir, logic sov, logic [31:0] res, logic ordy,
                              logic e_irdy, logic [3:0] e_siv, logic [3:0] e_sor, logic e_ov,
                              logic [31:0] e_wdat, logic [1:0] e_itag, logic e_ill, logic [31:0] e_rs1);
    vec_t v;
    v = '{iv, sel, rs1, itag, fl, unit, sir, sov, res, ordy,
          e_irdy, e_siv, e_sor, e_ov, e_wdat, e_itag, e_ill, e_rs1};
    vq.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Non-selected units are driven ready/valid high with junk data so a bad select decode shows up.
  task automatic drive(input vec_t v);
    i_valid = v.iv; i_sel = v.sel; i_rs1 = v.rs1; i_rs2 = ~v.rs1; i_itag = v.itag;
    flush = v.fl; o_ready = v.ordy;
    sub_i_ready = '1; sub_o_valid = '1;
    sub_i_ready[v.unit] = v.sir;
    sub_o_valid[v.unit] = v.sov;
    for (int k = 0; k < NSUB; k++)
      sub_o_wdat[32*k +: 32] = (k == v.unit) ? v.res : (32'hDEAD0000 | 32'(k));
  endtask

  task automatic idle_inputs();
    i_valid = 1'b0; i_sel = 3'd0; i_rs1 = 32'd0; i_rs2 = 32'd0; i_itag = 2'd0;
    flush = 1'b0; o_ready = 1'b0; sub_i_ready = '0; sub_o_valid = '0; sub_o_wdat = '0;
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_o_valid", 32'(o_valid), 32'd0);
    chk("rst_o_wdat", o_wdat, 32'd0);
    chk("rst_o_itag", 32'(o_itag), 32'd0);
    chk("rst_o_illegal", 32'(o_illegal), 32'd0);
    chk("rst_sub_rs2", sub_rs2, 32'd0);
    rst_n = 1'b1;

    // fclass pass-through on unit 0
    add(1,0,32'h7F800000,1,0, 0,0,0,32'h0,0,        1,4'h0,4'h0,0,32'h0,0,0,32'h0);
    add(0,0,32'h0,0,0,        0,1,1,32'h00000080,0, 0,4'h1,4'h1,0,32'h0,0,0,32'h7F800000);
    add(0,0,32'h0,0,0,        0,0,0,32'h0,1,        0,4'h0,4'h0,1,32'h00000080,1,0,32'h7F800000);
    // unit 2, 3-cycle latency, writeback stalls 4 cycles
    add(1,2,32'h3F000000,2,0, 2,0,0,32'h0,0,        1,4'h0,4'h0,0,32'h0,0,0,32'h7F800000);
    add(0,0,32'h0,0,0,        2,1,0,32'h0,0,        0,4'h4,4'h4,0,32'h0,0,0,32'h3F000000);
    add(0,0,32'h0,0,0,        2,0,0,32'h0,0,        0,4'h0,4'h4,0,32'h0,0,0,32'h3F000000);
    add(0,0,32'h0,0,0,        2,0,0,32'h0,0,        0,4'h0,4'h4,0,32'h0,0,0,32'h3F000000);
    add(0,0,32'h0,0,0,        2,0,1,32'h3F800000,0, 0,4'h0,4'h4,0,32'h0,0,0,32'h3F000000);
    for (int i = 0; i < 4; i++)
      add(0,0,32'h0,0,0,      2,0,0,32'h0,0,        0,4'h0,4'h0,1,32'h3F800000,2,0,32'h3F000000);
    add(0,0,32'h0,0,0,        2,0,0,32'h0,1,        0,4'h0,4'h0,1,32'h3F800000,2,0,32'h3F000000);
    // illegal select
    add(1,5,32'h11111111,3,0, 0,1,1,32'h0,0,        1,4'h0,4'h0,0,32'h0,0,0,32'h3F000000);
    add(0,0,32'h0,0,0,        0,1,1,32'h0,1,        0,4'h0,4'h0,1,32'h0,3,1,32'h11111111);
    // flush during WAIT on unit 1, late result consumed and dropped
    add(1,1,32'h22222222,0,0, 1,0,0,32'h0,0,        1,4'h0,4'h0,0,32'h0,0,0,32'h11111111);
    add(0,0,32'h0,0,0,        1,1,0,32'h0,0,        0,4'h2,4'h2,0,32'h0,0,0,32'h22222222);
    add(0,0,32'h0,0,1,        1,0,0,32'h0,0,        0,4'h0,4'h2,0,32'h0,0,0,32'h22222222);
    add(0,0,32'h0,0,0,        1,0,0,32'h0,0,        0,4'h0,4'h2,0,32'h0,0,0,32'h22222222);
    add(0,0,32'h0,0,0,        1,0,1,32'h12345678,0, 0,4'h0,4'h2,0,32'h0,0,0,32'h22222222);
    // next request completes normally
    add(1,1,32'h33333333,1,0, 1,0,0,32'h0,0,        1,4'h0,4'h0,0,32'h0,0,0,32'h22222222);
    add(0,0,32'h0,0,0,        1,1,1,32'hCAFEF00D,0, 0,4'h2,4'h2,0,32'h0,0,0,32'h33333333);
    add(0,0,32'h0,0,0,        1,0,0,32'h0,1,        0,4'h0,4'h0,1,32'hCAFEF00D,1,0,32'h33333333);
    // flush in ISSUE without handshake
    add(1,3,32'h44444444,2,0, 3,0,0,32'h0,0,        1,4'h0,4'h0,0,32'h0,0,0,32'h33333333);
    add(0,0,32'h0,0,1,        3,0,0,32'h0,0,        0,4'h8,4'h8,0,32'h0,0,0,32'h44444444);
    add(0,0,32'h0,0,0,        3,0,0,32'h0,0,        1,4'h0,4'h0,0,32'h0,0,0,32'h44444444);
    // flush in the accept cycle discards the request
    add(1,0,32'h44444444,0,1, 0,0,0,32'h0,0,        1,4'h0,4'h0,0,32'h0,0,0,32'h44444444);
    // flush together with issue handshake: kill, then drop the result
    add(1,2,32'h44444444,3,0, 2,0,0,32'h0,0,        1,4'h0,4'h0,0,32'h0,0,0,32'h44444444);
    add(0,0,32'h0,0,1,        2,1,0,32'h0,0,        0,4'h4,4'h4,0,32'h0,0,0,32'h44444444);
    add(0,0,32'h0,0,0,        2,0,1,32'h55555555,0, 0,4'h0,4'h4,0,32'h0,0,0,32'h44444444);
    add(0,0,32'h0,0,0,        2,0,0,32'h0,1,        1,4'h0,4'h0,0,32'h0,0,0,32'h44444444);
    add(0,0,32'h0,0,0,        2,0,0,32'h0,1,        1,4'h0,4'h0,0,32'h0,0,0,32'h44444444);

    foreach (vq[i]) begin
      @(negedge clk);
      drive(vq[i]);
      #1;
      chk($sformatf("r%0d_i_ready", i), 32'(i_ready), 32'(vq[i].e_irdy));
      chk($sformatf("r%0d_sub_i_valid", i), 32'(sub_i_valid), 32'(vq[i].e_siv));
      chk($sformatf("r%0d_sub_o_ready", i), 32'(sub_o_ready), 32'(vq[i].e_sor));
      chk($sformatf("r%0d_o_valid", i), 32'(o_valid), 32'(vq[i].e_ov));
      chk($sformatf("r%0d_sub_rs1", i), sub_rs1, vq[i].e_rs1);
      if (vq[i].e_rs1 != 32'h0)
        chk($sformatf("r%0d_sub_rs2", i), sub_rs2, ~vq[i].e_rs1);
      if (vq[i].e_ov) begin
        chk($sformatf("r%0d_o_wdat", i), o_wdat, vq[i].e_wdat);
        chk($sformatf("r%0d_o_itag", i), 32'(o_itag), 32'(vq[i].e_itag));
        chk($sformatf("r%0d_o_illegal", i), 32'(o_illegal), 32'(vq[i].e_ill));
      end
    end

    // asynchronous reset while in RESP
    @(negedge clk);
    idle_inputs();
    i_valid = 1'b1; i_sel = 3'd0; i_rs1 = 32'h66666666; i_itag = 2'd1;
    sub_i_ready = '1; sub_o_valid = '1; sub_o_wdat[31:0] = 32'h00000001;
    @(negedge clk);
    i_valid = 1'b0;
    #1;
    chk("ar_issue_sub_i_valid", 32'(sub_i_valid), 32'h1);
    @(negedge clk);
    #1;
    chk("ar_resp_o_valid", 32'(o_valid), 32'd1);
    chk("ar_resp_o_wdat", o_wdat, 32'h00000001);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_o_valid", 32'(o_valid), 32'd0);
    chk("ar_o_wdat", o_wdat, 32'd0);
    chk("ar_o_itag", 32'(o_itag), 32'd0);
    chk("ar_sub_i_valid", 32'(sub_i_valid), 32'd0);
    chk("ar_sub_o_ready", 32'(sub_o_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("ar_release_i_ready", 32'(i_ready), 32'd1);

    // asynchronous reset while in ISSUE
    @(negedge clk);
    i_valid = 1'b1; i_sel = 3'd3; i_rs1 = 32'h77777777; sub_i_ready = '0; sub_o_valid = '0;
    @(negedge clk);
    i_valid = 1'b0;
    #1;
    chk("ar2_issue_sub_i_valid", 32'(sub_i_valid), 32'h8);
    chk("ar2_issue_i_ready", 32'(i_ready), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar2_sub_i_valid", 32'(sub_i_valid), 32'd0);
    chk("ar2_sub_o_ready", 32'(sub_o_ready), 32'd0);
    chk("ar2_sub_rs1", sub_rs1, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("ar2_release_i_ready", 32'(i_ready), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end
endmodule

// File: doc/e203_exu_fpu_fmis_ctrl.md
# e203_exu_fpu_fmis_ctrl

Sequencer for the FPU miscellaneous-op sub-units: fclass, sign-inject, min/max, move and similar. It accepts one misc-op request at a time from the FPU dispatch and drives the shared operand bus to the selected sub-unit. It then waits for that sub-unit's result and holds the result in a registered output stage until the writeback accepts it. Pipeline flushes are honoured at every step, and any in-flight sub-unit transaction is drained cleanly.

## Interface
- NSUB, 4, number of sub-units (1..8)
- ITAG_W, 2, instruction tag width
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- i_valid  in  1  request valid
- i_ready  out  1  request accepted when i_valid & i_ready
- i_sel  in  3  sub-unit index
- i_rs1  in  32  operand 1
- i_rs2  in  32  operand 2
- i_itag  in  ITAG_W  tag, returned with the result
- flush  in  1  kill the current operation
- sub_i_valid  out  NSUB  one-hot issue valid
- sub_i_ready  in  NSUB  per-unit issue ready
- sub_rs1  out  32  registered operand 1 (shared)
- sub_rs2  out  32  registered operand 2 (shared)
- sub_o_valid  in  NSUB  per-unit result valid
- sub_o_ready  out  NSUB  one-hot result ready
- sub_o_wdat  in  32*NSUB  results; unit k is at bits [32k+31:32k]
- o_valid  out  1  result valid
- o_ready  in  1  writeback ready
- o_wdat  out  32  result
- o_itag  out  ITAG_W  tag of the result
- o_illegal  out  1  i_sel was >= NSUB; o_wdat is 0

## Operation
Clock and reset:
- Single clock domain. rst_n is asynchronous and active-low.
- All state is reset to: IDLE, kill=0, all operand/result/tag registers 0.

States:
- IDLE:
  - i_ready=1.
  - On accept, latch i_sel, i_rs1, i_rs2 and i_itag into registers.
  - If i_sel >= NSUB, set illegal=1 and wdat=0, then go to RESP.
  - Otherwise go to ISSUE.
  - A flush in the accept cycle wins: the request is accepted and discarded, and the state stays IDLE.
- ISSUE:
  - sub_i_valid[sel]=1; sub_o_ready[sel]=1 is asserted concurrently.
  - sub_i_ready[sel] & sub_o_valid[sel] in the same cycle (pass-through unit): capture the result and go to RESP.
  - sub_i_ready[sel] alone: go to WAIT.
  - Flush with no handshake: go to IDLE; the sub-unit is never issued.
  - Flush together with the issue handshake: set kill=1, then go to WAIT, or to IDLE if the result handshake also completed that cycle.
- WAIT:
  - sub_o_ready[sel]=1.
  - On sub_o_valid[sel]: if kill=0, capture the result and go to RESP. If kill=1, drop it, clear kill and go to IDLE.
  - A flush sets kill=1.
- RESP:
  - o_valid=1, with o_wdat, o_itag and o_illegal driven from registers.
  - o_ready: go to IDLE.
  - Flush: drop the result and go to IDLE. Flush has priority over o_ready.

Other rules:
- i_ready=0 in every state except IDLE. There is no back-to-back accept in the cycle that RESP completes.
- sub_i_valid and sub_o_ready are zero for every unit except sel, and are all-zero in IDLE and RESP.
- sub_rs1 and sub_rs2 are registers. They are stable from ISSUE until the state returns to IDLE.
- sel is 3 bits and is compared against NSUB without truncation.

## Timing
- Accept in cycle 0. ISSUE is cycle 1.
- Pass-through unit: o_valid in cycle 2, so minimum latency is 2 cycles accept-to-result.
- Unit with L cycles from issue handshake to result valid: o_valid appears L+1 cycles after the issue handshake.
- Illegal select: o_valid in cycle 1.
- The outputs are registered and hold stable while o_valid=1 & o_ready=0.
- Flush takes effect in the same cycle. o_valid is deasserted in the cycle after the flush and never re-asserts for the killed tag.
- Reset asserted mid-operation returns all outputs to 0 immediately (asynchronous). Sub-unit state is the sub-unit's own concern.

## Test plan
- fclass pass-through on unit 0 (sub_i_ready=1, sub_o_valid=sub_i_valid), i_rs1=0x7F800000, itag=1:
  - o_valid in cycle 2, o_wdat=0x00000080, o_itag=1, i_ready low in cycles 1-2.
- Unit 2 with 3-cycle latency, result 0x3F800000, o_ready held low for 4 cycles:
  - o_wdat stable at 0x3F800000 throughout the stall.
  - Single o_valid/o_ready handshake.
  - i_ready high the cycle after it.
- i_sel=5 with NSUB=4:
  - No sub_i_valid bit ever asserted.
  - o_valid in cycle 1, o_illegal=1, o_wdat=0.
- Flush during WAIT on unit 1; sub-unit result 0x12345678 arrives 2 cycles later:
  - Result consumed (sub_o_ready=1) but o_valid never asserted.
  - Return to IDLE; the next request completes normally.
- Flush in ISSUE with sub_i_ready=0:
  - sub_i_valid drops the next cycle, i_ready=1; the unit never sees a handshake.
- Assert rst_n=0 asynchronously while in RESP:
  - o_valid, sub_i_valid and sub_o_ready go to 0 before the next clock edge.
  - i_ready=1 after release.
